quark_axi_wr_ingress: RTL and testbench

//  AXI4 write-ingress stage sitting directly upstream of top_quark's cache side.

---
 rtl/quark_axi_wr_ingress.sv | 225 ++++++++++++++++++++++
 tb/tb_quark_axi_wr_ingress.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/quark_axi_wr_ingress.sv
// quark_axi_wr_ingress: AXI4 write ingress in front of the quark cache write port.
// Queues AW commands in a small FIFO, pairs each command with its W beats, and
// issues one cache write per beat with a generated byte address. One B response
// is returned per burst, in AW order, after the final beat reaches the cache.
//
// Ports
//   clk, rst_n                    clock, asynchronous active-low reset
//   s_aw*                         AXI write-address channel (slave side)
//   s_w*                          AXI write-data channel (slave side)
//   s_b*                          AXI write-response channel (slave side)
//   c_wr_valid/ready              cache write request handshake
//   c_wr_addr/data/strb/last      cache write payload for the current beat
module quark_axi_wr_ingress #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned ID_W     = 4,
  parameter int unsigned AW_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_awvalid,
  output logic                  s_awready,
  input  logic [ID_W-1:0]       s_awid,
  input  logic [ADDR_W-1:0]     s_awaddr,
  input  logic [7:0]            s_awlen,
  input  logic [2:0]            s_awsize,
  input  logic [1:0]            s_awburst,
  input  logic                  s_wvalid,
  output logic                  s_wready,
  input  logic [DATA_W-1:0]     s_wdata,
  input  logic [DATA_W/8-1:0]   s_wstrb,
  input  logic                  s_wlast,
  output logic                  s_bvalid,
  input  logic                  s_bready,
  output logic [ID_W-1:0]       s_bid,
  output logic [1:0]            s_bresp,
  output logic                  c_wr_valid,
  input  logic                  c_wr_ready,
  output logic [ADDR_W-1:0]     c_wr_addr,
  output logic [DATA_W-1:0]     c_wr_data,
  output logic [DATA_W/8-1:0]   c_wr_strb,
  output logic                  c_wr_last
);

  localparam int unsigned STRB_W   = DATA_W / 8;
  localparam int unsigned SIZE_MAX = $clog2(STRB_W);
  localparam int unsigned PTR_W    = (AW_DEPTH > 1) ? $clog2(AW_DEPTH) : 1;
  localparam int unsigned CNT_W    = PTR_W + 1;

  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_INCR  = 2'd1;
  localparam logic [1:0] BURST_WRAP  = 2'd2;
  localparam logic [1:0] BURST_RSVD  = 2'd3;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        len;
    logic [2:0]        size;
    logic [1:0]        burst;
  } aw_cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t state_q, state_nxt;

  // AW command FIFO
  aw_cmd_t            fifo_mem [AW_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   count_q, count_nxt;
  logic               awready_q;
  logic               fifo_empty;
  logic               push, pop;
  aw_cmd_t            head, aw_in;

  // Active burst
  logic [ID_W-1:0]    id_q;
  logic [ADDR_W-1:0]  addr_q, addr_nxt;
  logic [7:0]         len_q, beat_cnt_q;
  logic [2:0]         size_q;
  logic [1:0]         burst_q;
  logic               err_q, drop_q;

  logic               w_hs;
  logic               last_beat;
  logic               head_bad_size, head_bad_burst, head_bad_wrap;
  logic [ADDR_W-1:0]  step, addr_inc, wrap_mask;

  assign aw_in      = '{id: s_awid, addr: s_awaddr, len: s_awlen,
                        size: s_awsize, burst: s_awburst};
  assign fifo_empty = (count_q == '0);
  assign s_awready  = awready_q;
  assign push       = s_awvalid & awready_q;
  assign head       = fifo_mem[rd_ptr_q];
  assign count_nxt  = count_q + CNT_W'(push) - CNT_W'(pop);

  // FIFO storage carries no reset; occupancy is tracked by count_q
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= aw_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      awready_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q   <= count_nxt;
      // Registered !full, held low through reset
      awready_q <= (count_nxt != CNT_W'(AW_DEPTH));
    end
  end

  // Command legality, judged on the FIFO head at pop time
  assign head_bad_size  = (head.size > 3'(SIZE_MAX));
  assign head_bad_burst = (head.burst == BURST_RSVD);
  assign head_bad_wrap  = (head.burst == BURST_WRAP) &&
                          !((head.len == 8'd1) || (head.len == 8'd3) ||
                            (head.len == 8'd7) || (head.len == 8'd15));

  // Per-beat address generation
  assign last_beat = (beat_cnt_q == len_q);
  assign step      = ADDR_W'(1) << size_q;
  assign addr_inc  = addr_q + step;
  assign wrap_mask = ((ADDR_W'(len_q) + ADDR_W'(1)) << size_q) - ADDR_W'(1);

  always_comb begin
    addr_nxt = addr_q;
    case (burst_q)
      BURST_FIXED: addr_nxt = addr_q;
      BURST_INCR:  addr_nxt = addr_inc;
      BURST_WRAP:  addr_nxt = (addr_q & ~wrap_mask) | (addr_inc & wrap_mask);
      default:     addr_nxt = addr_q;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_nxt;
  end

  // FSM next state and channel outputs
  always_comb begin
    state_nxt  = state_q;
    pop        = 1'b0;
    w_hs       = 1'b0;
    s_wready   = 1'b0;
    s_bvalid   = 1'b0;
    s_bid      = '0;
    s_bresp    = RESP_OKAY;
    c_wr_valid = 1'b0;
    c_wr_addr  = '0;
    c_wr_data  = '0;
    c_wr_strb  = '0;
    c_wr_last  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        if (drop_q) begin
          s_wready = 1'b1;
        end else begin
          s_wready   = c_wr_ready;
          c_wr_valid = s_wvalid;
          c_wr_addr  = addr_q;
          c_wr_data  = s_wdata;
          c_wr_strb  = s_wstrb;
          c_wr_last  = last_beat;
        end
        w_hs = s_wvalid & s_wready;
        if (w_hs && last_beat) state_nxt = ST_RESP;
      end
      ST_RESP: begin
        s_bvalid = 1'b1;
        s_bid    = id_q;
        s_bresp  = err_q ? RESP_SLVERR : RESP_OKAY;
        if (s_bready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Burst registers: loaded on pop, advanced on every W handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_q       <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      size_q     <= '0;
      burst_q    <= BURST_FIXED;
      beat_cnt_q <= '0;
      err_q      <= 1'b0;
      drop_q     <= 1'b0;
    end else if (pop) begin
      id_q       <= head.id;
      addr_q     <= head.addr;
      len_q      <= head.len;
      size_q     <= head.size;
      // A WRAP with an unsupported length is answered SLVERR and addressed as INCR
      burst_q    <= head_bad_wrap ? BURST_INCR : head.burst;
      beat_cnt_q <= '0;
      drop_q     <= head_bad_size | head_bad_burst;
      err_q      <= head_bad_size | head_bad_burst | head_bad_wrap;
    end else if (w_hs) begin
      beat_cnt_q <= beat_cnt_q + 8'd1;
      addr_q     <= addr_nxt;
      if (s_wlast != last_beat) err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_quark_axi_wr_ingress.sv
// Bench for quark_axi_wr_ingress: directed scenarios plus randomized bursts,
// checked against a queue-based model of expected cache writes and B responses.
module tb_quark_axi_wr_ingress;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned ID_W   = 4;
  localparam int unsigned STRB_W = DATA_W / 8;

  logic              clk, rst_n;
  logic              s_awvalid, s_awready;
  logic [ID_W-1:0]   s_awid;
  logic [ADDR_W-1:0] s_awaddr;
  logic [7:0]        s_awlen;
  logic [2:0]        s_awsize;
  logic [1:0]        s_awburst;
  logic              s_wvalid, s_wready;
  logic [DATA_W-1:0] s_wdata;
  logic [STRB_W-1:0] s_wstrb;
  logic              s_wlast;
  logic              s_bvalid, s_bready;
  logic [ID_W-1:0]   s_bid;
  logic [1:0]        s_bresp;
  logic              c_wr_valid, c_wr_ready;
  logic [ADDR_W-1:0] c_wr_addr;
  logic [DATA_W-1:0] c_wr_data;
  logic [STRB_W-1:0] c_wr_strb;
  logic              c_wr_last;

  quark_axi_wr_ingress #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .AW_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awid(s_awid), .s_awaddr(s_awaddr),
    .s_awlen(s_awlen), .s_awsize(s_awsize), .s_awburst(s_awburst),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_wlast(s_wlast),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bid(s_bid), .s_bresp(s_bresp),
    .c_wr_valid(c_wr_valid), .c_wr_ready(c_wr_ready), .c_wr_addr(c_wr_addr),
    .c_wr_data(c_wr_data), .c_wr_strb(c_wr_strb), .c_wr_last(c_wr_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    int          wlast_beat;
  } bur_t;
  typedef struct {
    logic [31:0] addr;
    logic [63:0] data;
    logic [7:0]  strb;
    logic        last;
  } cw_t;
  typedef struct {
    logic [3:0] id;
    logic [1:0] resp;
  } b_t;

  bur_t        aw_q[$], w_q[$];
  cw_t         exp_c[$];
  b_t          exp_b[$], obs_b[$];
  logic [31:0] obs_addr[$];
  logic        obs_last[$];

  int   n_cmp, n_fail;
  int   cw_mode, b_mode;
  bit   aw_gap, w_gap;
  bit   aw_pres, w_pres, aw_hs_f, w_hs_f, b_wait;
  int   wbeat;
  logic [3:0] b_id_prev;
  logic [1:0] b_resp_prev;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic bit wrap_len_ok(bur_t b);
    return (b.len == 8'd1) || (b.len == 8'd3) || (b.len == 8'd7) || (b.len == 8'd15);
  endfunction

  function automatic bit is_written(bur_t b);
    return (b.size <= 3'd3) && (b.burst != 2'd3);
  endfunction

  function automatic logic [1:0] exp_resp(bur_t b);
    bit bad;
    bad = !is_written(b) || (b.burst == 2'd2 && !wrap_len_ok(b)) || (b.wlast_beat != int'(b.len));
    return bad ? 2'b10 : 2'b00;
  endfunction

  // Byte address of beat i from plain burst arithmetic
  function automatic logic [31:0] beat_addr(bur_t b, int i);
    logic [31:0] st, bytes, base;
    st = 32'd1 << b.size;
    if (b.burst == 2'd0) return b.addr;
    if (b.burst == 2'd2 && wrap_len_ok(b)) begin
      bytes = (32'(b.len) + 32'd1) * st;
      base  = b.addr - (b.addr % bytes);
      return base + ((b.addr - base + 32'(i) * st) % bytes);
    end
    return b.addr + 32'(i) * st;
  endfunction

  task automatic add_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input int wlb);
    bur_t b;
    b = '{id: id, addr: addr, len: len, size: size, burst: burst, wlast_beat: wlb};
    aw_q.push_back(b);
    w_q.push_back(b);
  endtask

  task automatic flush();
    aw_q.delete(); w_q.delete(); exp_c.delete(); exp_b.delete();
    aw_pres = 0; w_pres = 0; wbeat = 0; aw_hs_f = 0; w_hs_f = 0; b_wait = 0;
    s_awvalid = 0; s_wvalid = 0;
  endtask

  task automatic clear_obs();
    obs_addr.delete(); obs_last.delete(); obs_b.delete();
  endtask

  task automatic wait_idle(input int budget, input string name);
    int cyc;
    cyc = 0;
    while ((aw_q.size() != 0 || w_q.size() != 0 || exp_c.size() != 0 || exp_b.size() != 0 ||
            aw_pres || w_pres) && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    n_cmp++;
    if (cyc >= budget) begin
      n_fail++;
      $display("FAIL %s_timeout: pending aw=%0d w=%0d c=%0d b=%0d", name,
               aw_q.size(), w_q.size(), exp_c.size(), exp_b.size());
    end
    repeat (3) @(negedge clk);
  endtask

  // Compare at negedge, then drive new inputs 1 time unit after posedge
  initial begin : tick
    cw_t  e;
    b_t   eb;
    bur_t b;
    forever begin
      @(negedge clk);
      aw_hs_f = 0;
      w_hs_f  = 0;
      if (rst_n) begin
        aw_hs_f = s_awvalid && s_awready;
        w_hs_f  = s_wvalid && s_wready;
        if (c_wr_valid) chk("c_valid_passthru", 64'(s_wvalid), 64'd1);
        if (c_wr_valid && c_wr_ready) begin
          if (exp_c.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL c_unexpected_beat: got addr 0x%0h with no beat expected", c_wr_addr);
          end else begin
            e = exp_c.pop_front();
            chk("c_addr", 64'(c_wr_addr), 64'(e.addr));
            chk("c_data", c_wr_data, e.data);
            chk("c_strb", 64'(c_wr_strb), 64'(e.strb));
            chk("c_last", 64'(c_wr_last), 64'(e.last));
          end
          obs_addr.push_back(c_wr_addr);
          obs_last.push_back(c_wr_last);
        end
        if (b_wait) begin
          chk("b_hold_valid", 64'(s_bvalid), 64'd1);
          chk("b_hold_id", 64'(s_bid), 64'(b_id_prev));
          chk("b_hold_resp", 64'(s_bresp), 64'(b_resp_prev));
        end
        if (s_bvalid && s_bready) begin
          if (exp_b.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL b_unexpected: got id %0d with no response expected", s_bid);
          end else begin
            eb = exp_b.pop_front();
            chk("b_id", 64'(s_bid), 64'(eb.id));
            chk("b_resp", 64'(s_bresp), 64'(eb.resp));
          end
          obs_b.push_back('{id: s_bid, resp: s_bresp});
        end
        b_wait      = s_bvalid && !s_bready;
        b_id_prev   = s_bid;
        b_resp_prev = s_bresp;
      end else begin
        b_wait = 0;
      end
      @(posedge clk);
      #1;
      if (rst_n) begin
        if (aw_hs_f) begin
          b = aw_q.pop_front();
          exp_b.push_back('{id: b.id, resp: exp_resp(b)});
          aw_pres = 0;
        end
        if (!aw_pres && aw_q.size() != 0 && (!aw_gap || $urandom_range(3) != 0)) begin
          s_awid = aw_q[0].id; s_awaddr = aw_q[0].addr; s_awlen = aw_q[0].len;
          s_awsize = aw_q[0].size; s_awburst = aw_q[0].burst;
          aw_pres = 1;
        end
        s_awvalid = aw_pres;
        if (w_hs_f) begin
          w_pres = 0;
          wbeat++;
          if (wbeat > int'(w_q[0].len)) begin
            void'(w_q.pop_front());
            wbeat = 0;
          end
        end
        if (!w_pres && w_q.size() != 0 && (!w_gap || $urandom_range(3) != 0)) begin
          b = w_q[0];
          s_wdata = {$urandom, $urandom};
          s_wstrb = 8'($urandom);
          s_wlast = (wbeat == b.wlast_beat);
          w_pres  = 1;
          if (is_written(b))
            exp_c.push_back('{addr: beat_addr(b, wbeat), data: s_wdata, strb: s_wstrb,
                              last: (wbeat == int'(b.len))});
        end
        s_wvalid = w_pres;
      end
      case (cw_mode)
        1:       c_wr_ready = 1'b1;
        2:       c_wr_ready = ~c_wr_ready;
        3:       c_wr_ready = 1'b0;
        default: c_wr_ready = ($urandom_range(3) != 0);
      endcase
      case (b_mode)
        1:       s_bready = 1'b1;
        3:       s_bready = 1'b0;
        default: s_bready = ($urandom_range(1) != 0);
      endcase
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [31:0] t1_addr[4];
    logic [31:0] t2_addr[4];
    int          cyc;
    int          n;
    logic [7:0]  len;
    logic [1:0]  bt;
    logic [2:0]  sz;
    int          wlb;

    t1_addr = '{32'h100, 32'h108, 32'h110, 32'h118};
    t2_addr = '{32'h118, 32'h100, 32'h108, 32'h110};
    n_cmp = 0; n_fail = 0;
    cw_mode = 1; b_mode = 1; aw_gap = 0; w_gap = 0;
    rst_n = 0;
    s_awvalid = 0; s_awid = '0; s_awaddr = '0; s_awlen = '0; s_awsize = '0; s_awburst = '0;
    s_wvalid = 0; s_wdata = '0; s_wstrb = '0; s_wlast = 0;
    s_bready = 0; c_wr_ready = 0;
    flush();

    // Reset values
    #12;
    chk("rst_awready", 64'(s_awready), 64'd0);
    chk("rst_wready", 64'(s_wready), 64'd0);
    chk("rst_bvalid", 64'(s_bvalid), 64'd0);
    chk("rst_c_valid", 64'(c_wr_valid), 64'd0);
    chk("rst_bresp", 64'(s_bresp), 64'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1;
    repeat (2) @(negedge clk);

    // INCR len=3 size=3
    clear_obs();
    add_burst(4'd3, 32'h100, 8'd3, 3'd3, 2'd1, 3);
    wait_idle(200, "t1");
    chk("t1_beats", 64'(obs_addr.size()), 64'd4);
    for (int i = 0; i < 4; i++)
      if (i < obs_addr.size()) begin
        chk($sformatf("t1_addr%0d", i), 64'(obs_addr[i]), 64'(t1_addr[i]));
        chk($sformatf("t1_last%0d", i), 64'(obs_last[i]), 64'(i == 3));
      end
    chk("t1_nb", 64'(obs_b.size()), 64'd1);
    if (obs_b.size() != 0) begin
      chk("t1_bid", 64'(obs_b[0].id), 64'd3);
      chk("t1_bresp", 64'(obs_b[0].resp), 64'd0);
    end

    // WRAP then FIXED
    clear_obs();
    add_burst(4'd5, 32'h118, 8'd3, 3'd3, 2'd2, 3);
    add_burst(4'd6, 32'h40, 8'd2, 3'd2, 2'd0, 2);
    wait_idle(300, "t2");
    chk("t2_beats", 64'(obs_addr.size()), 64'd7);
    for (int i = 0; i < 7; i++)
      if (i < obs_addr.size())
        chk($sformatf("t2_addr%0d", i), 64'(obs_addr[i]), (i < 4) ? 64'(t2_addr[i]) : 64'h40);

    // Cache back-pressure toggling
    cw_mode = 2;
    for (int i = 0; i < 4; i++)
      add_burst(4'(i), 32'h1000 + 32'(i) * 32'h80, 8'(i + 2), 3'd3, 2'd1, i + 2);
    wait_idle(500, "t3a");

    // B back-pressure for 10 cycles
    cw_mode = 1; b_mode = 3;
    add_burst(4'd11, 32'h2000, 8'd1, 3'd3, 2'd1, 1);
    cyc = 0;
    while (!s_bvalid && cyc < 200) begin @(negedge clk); cyc++; end
    chk("t3b_bvalid_seen", 64'(s_bvalid), 64'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t3b_bvalid", 64'(s_bvalid), 64'd1);
      chk("t3b_bid", 64'(s_bid), 64'd11);
      chk("t3b_wready", 64'(s_wready), 64'd0);
    end
    b_mode = 1;
    wait_idle(200, "t3b");

    // AW FIFO fill with first burst stalled
    clear_obs();
    cw_mode = 3;
    for (int i = 1; i <= 6; i++)
      add_burst(4'(i), 32'h3000 + 32'(i) * 32'h10, 8'd1, 3'd3, 2'd1, 1);
    repeat (30) @(negedge clk);
    chk("t4_awready_full", 64'(s_awready), 64'd0);
    chk("t4_aw_pending", 64'(aw_q.size()), 64'd1);
    cw_mode = 1;
    wait_idle(500, "t4");
    chk("t4_nb", 64'(obs_b.size()), 64'd6);
    for (int i = 0; i < 6; i++)
      if (i < obs_b.size()) chk($sformatf("t4_border%0d", i), 64'(obs_b[i].id), 64'(i + 1));

    // Early wlast, then illegal size
    clear_obs();
    add_burst(4'd7, 32'h200, 8'd3, 3'd3, 2'd1, 2);
    add_burst(4'd8, 32'h280, 8'd2, 3'd4, 2'd1, 2);
    wait_idle(300, "t5");
    chk("t5_beats", 64'(obs_addr.size()), 64'd4);
    chk("t5_nb", 64'(obs_b.size()), 64'd2);
    if (obs_b.size() == 2) begin
      chk("t5_wlast_resp", 64'(obs_b[0].resp), 64'd2);
      chk("t5_size_resp", 64'(obs_b[1].resp), 64'd2);
    end

    // Reset in the middle of a burst
    clear_obs();
    add_burst(4'd9, 32'h300, 8'd3, 3'd3, 2'd1, 3);
    cyc = 0;
    while (obs_addr.size() == 0 && cyc < 200) begin @(negedge clk); cyc++; end
    chk("t6_first_beat", 64'(obs_addr.size()), 64'd1);
    #2;
    rst_n = 0;
    #1;
    chk("t6_awready", 64'(s_awready), 64'd0);
    chk("t6_wready", 64'(s_wready), 64'd0);
    chk("t6_c_valid", 64'(c_wr_valid), 64'd0);
    chk("t6_bvalid", 64'(s_bvalid), 64'd0);
    flush();
    repeat (3) @(negedge clk);
    rst_n = 1;
    repeat (2) @(negedge clk);
    clear_obs();
    add_burst(4'd10, 32'h400, 8'd1, 3'd3, 2'd1, 1);
    wait_idle(200, "t6");
    chk("t6_beats", 64'(obs_addr.size()), 64'd2);
    if (obs_addr.size() == 2) begin
      chk("t6_addr0", 64'(obs_addr[0]), 64'h400);
      chk("t6_addr1", 64'(obs_addr[1]), 64'h408);
    end
    chk("t6_nb", 64'(obs_b.size()), 64'd1);
    if (obs_b.size() == 1) chk("t6_bid", 64'(obs_b[0].id), 64'd10);

    // Randomized bursts under random back-pressure
    cw_mode = 0; b_mode = 0; aw_gap = 1; w_gap = 1;
    n = 60;
    for (int i = 0; i < n; i++) begin
      bt = ($urandom_range(19) == 0) ? 2'd3 : 2'($urandom_range(2));
      if (bt == 2'd2) begin
        case ($urandom_range(3))
          0: len = 8'd1;
          1: len = 8'd3;
          2: len = 8'd7;
          default: len = 8'd15;
        endcase
      end else begin
        len = 8'($urandom_range(7));
      end
      sz  = ($urandom_range(9) == 0) ? 3'($urandom_range(7, 4)) : 3'($urandom_range(3));
      wlb = ($urandom_range(9) == 0) ? int'($urandom_range(int'(len))) : int'(len);
      add_burst(4'($urandom), $urandom, len, sz, bt, wlb);
    end
    wait_idle(20000, "rand");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
